contr_ram_fifo_tx: RTL

CONTR_RAM_FIFO_TX -- requirements
Module: contr_ram_fifo_tx

---
 rtl/contr_ram_fifo_tx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/contr_ram_fifo_tx.sv
// contr_ram_fifo_tx
// Copies a block of bytes from a synchronous RAM into a TX FIFO, and
// independently drains that FIFO into a UART transmitter one byte at a time.
//
// Ports
//   clk, rst_n        system clock (rising edge), asynchronous active-low reset
//   start, len        transfer request level (rising edge starts) and byte count
//   ram_addr/ram_rden RAM read address and one-cycle read strobe
//   ram_q             RAM read data, valid the cycle after ram_rden
//   wrfull/wrreq      TX FIFO full flag and one-cycle write strobe
//   wrdata            TX FIFO write data
//   rdempty/rdreq     TX FIFO empty flag and one-cycle read strobe
//   fifo_q            TX FIFO read data, valid the cycle after rdreq
//   tx_busy           UART busy, rises the cycle after tx_en
//   tx_data/tx_en     byte and one-cycle strobe to the UART
//   busy, done        fill engine active / one-cycle end-of-transfer pulse
module contr_ram_fifo_tx #(
  parameter logic [7:0] BASE_ADDR = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] len,
  output logic [7:0] ram_addr,
  output logic       ram_rden,
  input  logic [7:0] ram_q,
  input  logic       wrfull,
  output logic       wrreq,
  output logic [7:0] wrdata,
  input  logic       rdempty,
  output logic       rdreq,
  input  logic [7:0] fifo_q,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {F_IDLE, F_ADDR, F_DATA, F_DONE} fillState_t;
  typedef enum logic [2:0] {T_IDLE, T_POP, T_LOAD, T_GUARD, T_WAIT} txState_t;

  logic       r_start1;
  logic       r_start2;
  logic       r_startSeen;
  logic       w_startEdge;

  fillState_t r_fillState;
  fillState_t w_fillNext;
  logic [7:0] r_ramAddr;
  logic [7:0] r_cnt;
  logic [7:0] r_wrdata;
  logic       r_wrreq;
  logic       r_done;
  logic       w_ramRden;
  logic       w_busy;

  txState_t   r_txState;
  txState_t   w_txNext;
  logic [7:0] r_txData;
  logic       r_txEn;
  logic       w_rdreq;

  // Start edge detector. On the first clock after reset both stages load the
  // same sampled level, so a start held high through reset release is not
  // mistaken for a fresh request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start1    <= 1'b0;
      r_start2    <= 1'b0;
      r_startSeen <= 1'b0;
    end else begin
      r_startSeen <= 1'b1;
      r_start1    <= start;
      r_start2    <= r_startSeen ? r_start1 : start;
    end
  end

  assign w_startEdge = r_start1 & ~r_start2;

  // Fill FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fillState <= F_IDLE;
    else        r_fillState <= w_fillNext;
  end

  // Fill FSM next state. Edges seen outside F_IDLE are simply dropped, and a
  // zero length never leaves idle. r_cnt==1 in F_DATA means the byte being
  // written now is the last one.
  always_comb begin
    w_fillNext = r_fillState;
    case (r_fillState)
      F_IDLE:  if (w_startEdge && (len != 8'd0)) w_fillNext = F_ADDR;
      F_ADDR:  if (!wrfull) w_fillNext = F_DATA;
      F_DATA:  w_fillNext = (r_cnt == 8'd1) ? F_DONE : F_ADDR;
      F_DONE:  w_fillNext = F_IDLE;
      default: w_fillNext = F_IDLE;
    endcase
  end

  // Fill FSM outputs. The RAM read is issued only when the FIFO can accept the
  // byte, so a full FIFO stalls the engine before any data is fetched.
  always_comb begin
    w_ramRden = (r_fillState == F_ADDR) && !wrfull;
    w_busy    = (r_fillState != F_IDLE);
  end

  // Fill datapath: address/count load, RAM-to-FIFO byte move and done pulse.
  // ram_q is valid in F_DATA because the read was issued in F_ADDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ramAddr <= 8'd0;
      r_cnt     <= 8'd0;
      r_wrdata  <= 8'd0;
      r_wrreq   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wrreq <= 1'b0;
      r_done  <= 1'b0;
      case (r_fillState)
        F_IDLE: begin
          if (w_fillNext == F_ADDR) begin
            r_ramAddr <= BASE_ADDR;
            r_cnt     <= len;
          end
        end
        F_DATA: begin
          r_wrdata  <= ram_q;
          r_wrreq   <= 1'b1;
          r_ramAddr <= r_ramAddr + 8'd1;
          r_cnt     <= r_cnt - 8'd1;
        end
        F_DONE:  r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_txState <= T_IDLE;
    else        r_txState <= w_txNext;
  end

  // Drain FSM next state. T_GUARD covers the cycle in which tx_en is visible
  // but the UART has not yet raised tx_busy.
  always_comb begin
    w_txNext = r_txState;
    case (r_txState)
      T_IDLE:  if (!rdempty && !tx_busy) w_txNext = T_POP;
      T_POP:   w_txNext = T_LOAD;
      T_LOAD:  w_txNext = T_GUARD;
      T_GUARD: w_txNext = T_WAIT;
      T_WAIT:  if (!tx_busy) w_txNext = T_IDLE;
      default: w_txNext = T_IDLE;
    endcase
  end

  // Drain FSM outputs.
  always_comb begin
    w_rdreq = (r_txState == T_IDLE) && !rdempty && !tx_busy;
  end

  // Drain datapath: the popped byte and its strobe leave together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txData <= 8'd0;
      r_txEn   <= 1'b0;
    end else begin
      r_txEn <= 1'b0;
      if (r_txState == T_LOAD) begin
        r_txData <= fifo_q;
        r_txEn   <= 1'b1;
      end
    end
  end

  assign ram_addr = r_ramAddr;
  assign ram_rden = w_ramRden;
  assign wrreq    = r_wrreq;
  assign wrdata   = r_wrdata;
  assign rdreq    = w_rdreq;
  assign tx_data  = r_txData;
  assign tx_en    = r_txEn;
  assign busy     = w_busy;
  assign done     = r_done;

endmodule
